// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller
//   Scans a 4x4 active-low keypad matrix, debounces presses and releases,
//   and queues accepted key codes in a small FIFO read over a register port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SCAN     | step through rows, one row per sample tick, looking for cols!=F
//   DEBOUNCE | row held, counting consecutive samples equal to the latched one
//   HELD     | key accepted and pushed; wait for all cols to read high
//   RELEASE  | row held, counting consecutive all-high samples
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous active-high reset
//   rows[3:0]    row drive, active-low one-hot (4'hF when idle/disabled)
//   cols[3:0]    column sense, 0 = key closed
//   address[3:0] register select: 0x0 KEY, 0x4 STATUS, 0x8 CTRL
//   din[31:0]    write data
//   writeEnable  write strobe
//   readEnable   read strobe
//   dout[31:0]   registered read data, zero when not reading
//   irq          CTRL.irq_en AND FIFO not empty
module keypad_scan_controller #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  rows,
  input  logic [3:0]  cols,
  input  logic [3:0]  address,
  input  logic [31:0] din,
  input  logic        writeEnable,
  input  logic        readEnable,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  sample_q, sample_d;
  logic [15:0] dwell_q;
  logic        enable_q, irq_en_q, overflow_q;
  logic        tick, push, push_ok, pop, flush, full, empty;
  logic [3:0]  key_cols;
  logic [1:0]  col_idx;
  logic [3:0]  code;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count_q;

  assign tick = enable_q && (dwell_q == 16'(SCAN_DIV - 1));
  assign rows = enable_q ? ~(4'b0001 << row_q) : 4'hF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  dwell_q <= '0;
    else if (!enable_q || tick) dwell_q <= '0;
    else                        dwell_q <= dwell_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SCAN;
      row_q    <= '0;
      cnt_q    <= '0;
      sample_q <= 4'hF;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    push     = 1'b0;
    if (!enable_q) begin
      state_d = SCAN;
      cnt_d   = '0;
    end else if (tick) begin
      case (state_q)
        SCAN: begin
          if (cols != 4'hF) begin
            sample_d = cols;
            cnt_d    = 4'd1;
            if (DEBOUNCE_SCANS <= 1) begin
              state_d = HELD;
              push    = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          // sample_q is never 4'hF here, so a match also means a closed key
          if (cols == sample_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 >= 4'(DEBOUNCE_SCANS)) begin
              state_d = HELD;
              push    = 1'b1;
            end
          end else begin
            state_d = SCAN;
            row_d   = row_q + 2'd1;
          end
        end
        HELD: begin
          if (cols == 4'hF) begin
            cnt_d = 4'd1;
            if (DEBOUNCE_SCANS <= 1) begin
              state_d = SCAN;
              row_d   = row_q + 2'd1;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (cols == 4'hF) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 >= 4'(DEBOUNCE_SCANS)) begin
              state_d = SCAN;
              row_d   = row_q + 2'd1;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Lowest closed column wins; in SCAN the live cols are the sample.
  assign key_cols = (state_q == SCAN) ? cols : sample_q;

  always_comb begin
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!key_cols[i]) col_idx = 2'(i);
    end
  end

  assign code = {row_q, col_idx};

  assign full    = (count_q == 5'(FIFO_DEPTH));
  assign empty   = (count_q == 5'd0);
  assign pop     = readEnable && (address == 4'h0) && !empty;
  assign flush   = writeEnable && (address == 4'h8) && din[2];
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 5'd1;
      else if (!push_ok && pop) count_q <= count_q - 5'd1;
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
    end else if (writeEnable && (address == 4'h8)) begin
      enable_q <= din[0];
      irq_en_q <= din[1];
    end
  end

  // Read data reflects state before any same-cycle write or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (readEnable) begin
      case (address)
        4'h0:    dout <= pop ? {1'b1, 27'b0, mem[rd_ptr]} : 32'h0;
        4'h4:    dout <= {24'b0, count_q, full, empty, overflow_q};
        4'h8:    dout <= {29'b0, 1'b0, irq_en_q, enable_q};
        default: dout <= 32'h0;
      endcase
    end else begin
      dout <= 32'h0;
    end
  end

  assign irq = irq_en_q && !empty;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb_keypad_scan_controller
//   Directed bench for keypad_scan_controller with SCAN_DIV=4,
//   DEBOUNCE_SCANS=2, FIFO_DEPTH=4. A behavioural keypad drives cols
//   low only while the pressed key's row is driven.
module tb_keypad_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows, cols, address;
  logic [31:0] din, dout;
  logic        writeEnable, readEnable, irq;

  logic        key_down;
  logic [1:0]  key_row, key_col;
  logic [31:0] d;

  int checks = 0;
  int errors = 0;

  keypad_scan_controller #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols), .address(address),
    .din(din), .writeEnable(writeEnable), .readEnable(readEnable),
    .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  assign cols = (key_down && rows == ~(4'b0001 << key_row)) ? ~(4'b0001 << key_col) : 4'hF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    writeEnable = 1'b1; address = a; din = v;
    @(negedge clk);
    writeEnable = 1'b0; din = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    readEnable = 1'b1; address = a;
    @(negedge clk);
    readEnable = 1'b0;
    v = dout;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_row = r; key_col = c; key_down = 1'b1;
    cyc(60);
    key_down = 1'b0;
    cyc(40);
  endtask

  // Returns at the first negedge of a fresh dwell on row value v.
  task automatic wait_row_start(input logic [3:0] v);
    int n;
    n = 0;
    while (rows == v && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (rows != v && n < 100) begin @(negedge clk); n++; end
    check("wait_row_start", {28'b0, rows}, {28'b0, v});
  endtask

  initial begin
    reset = 1'b1; key_down = 1'b0; key_row = '0; key_col = '0;
    address = '0; din = '0; writeEnable = 1'b0; readEnable = 1'b0;
    #1;
    check("reset_rows", {28'b0, rows}, 32'hF);
    check("reset_dout", dout, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    cyc(2);
    reset = 1'b0;

    // single key, row 2 col 1
    wr(4'h8, 32'h1);
    key_row = 2'd2; key_col = 2'd1; key_down = 1'b1;
    cyc(60);
    rd(4'h4, d); check("held_status", d, 32'h08);
    key_down = 1'b0;
    cyc(40);
    rd(4'h0, d); check("key_9", d, 32'h8000_0009);
    rd(4'h0, d); check("key_empty", d, 32'h0);
    rd(4'h4, d); check("status_empty", d, 32'h02);
    rd(4'h8, d); check("ctrl_enable", d, 32'h1);
    cyc(1);      check("dout_idle", dout, 32'h0);

    // bounce: closed for exactly one sample tick on row 1
    key_row = 2'd1; key_col = 2'd3;
    wait_row_start(4'hD);
    key_down = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    key_down = 1'b0;
    cyc(40);
    rd(4'h4, d); check("bounce_status", d, 32'h02);

    // interrupt
    wr(4'h8, 32'h3);
    check("irq_idle", {31'b0, irq}, 32'h0);
    key_row = 2'd0; key_col = 2'd0; key_down = 1'b1;
    cyc(60);
    check("irq_set", {31'b0, irq}, 32'h1);
    key_down = 1'b0;
    cyc(40);
    rd(4'h0, d); check("key_0", d, 32'h8000_0000);
    check("irq_clear", {31'b0, irq}, 32'h0);

    // overflow: five keys, FIFO holds four
    press(2'd0, 2'd2);
    press(2'd1, 2'd1);
    press(2'd3, 2'd3);
    press(2'd2, 2'd0);
    press(2'd3, 2'd2);
    rd(4'h4, d); check("ovf_status", d, 32'h25);
    rd(4'h0, d); check("ovf_key0", d, 32'h8000_0002);
    rd(4'h0, d); check("ovf_key1", d, 32'h8000_0005);
    rd(4'h0, d); check("ovf_key2", d, 32'h8000_000F);
    rd(4'h0, d); check("ovf_key3", d, 32'h8000_0008);
    rd(4'h0, d); check("ovf_drained", d, 32'h0);
    rd(4'h4, d); check("ovf_sticky", d, 32'h03);
    wr(4'h8, 32'h7);
    rd(4'h4, d); check("flush_status", d, 32'h02);
    rd(4'h8, d); check("flush_ctrl", d, 32'h3);

    // pop of last entry coincident with a push
    press(2'd1, 2'd2);
    key_row = 2'd2; key_col = 2'd3;
    wait_row_start(4'hB);
    key_down = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rd(4'h0, d); check("pp_pop", d, 32'h8000_0006);
    rd(4'h4, d); check("pp_count", d, 32'h08);
    key_down = 1'b0;
    cyc(40);
    rd(4'h0, d); check("pp_new", d, 32'h8000_000B);
    rd(4'h4, d); check("pp_empty", d, 32'h02);

    // reset while HELD
    key_row = 2'd3; key_col = 2'd1; key_down = 1'b1;
    cyc(60);
    check("held_irq", {31'b0, irq}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_rows", {28'b0, rows}, 32'hF);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc(60);
    check("rst_idle_rows", {28'b0, rows}, 32'hF);
    rd(4'h4, d); check("rst_status", d, 32'h02);
    rd(4'h8, d); check("rst_ctrl", d, 32'h0);
    wr(4'h8, 32'h1);
    cyc(60);
    rd(4'h4, d); check("reen_status", d, 32'h08);
    key_down = 1'b0;
    cyc(40);
    rd(4'h0, d); check("reen_key", d, 32'h8000_000D);

    // read and write of CTRL in the same cycle
    readEnable = 1'b1; writeEnable = 1'b1; address = 4'h8; din = 32'h0;
    @(negedge clk);
    readEnable = 1'b0; writeEnable = 1'b0;
    check("rw_prewrite", dout, 32'h1);
    rd(4'h8, d); check("rw_postwrite", d, 32'h0);
    check("rw_rows", {28'b0, rows}, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
